// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register-index width,
// scoreboard entry layout and the empty (NOP) entry encoding.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_DEPTH = 4;

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic [REG_DEPTH-1:0] dst;
        logic                 mem_read;
    } sb_entry_t;

    localparam int SB_ENTRY_W = $bits(sb_entry_t);

    localparam sb_entry_t SB_NOP = '{valid: 1'b0, wb_en: 1'b0, dst: '0, mem_read: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage request and pipeline-control bundle between the core datapath
// (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int CNT_WIDTH  = 16
);
    logic                  id_valid;
    logic [REG_DEPTH-1:0]  id_src1;
    logic [REG_DEPTH-1:0]  id_src2;
    logic                  id_two_src;
    logic                  id_wb_en;
    logic [REG_DEPTH-1:0]  id_dst;
    logic                  id_mem_read;
    logic                  branch_taken;
    logic                  mem_ready;
    logic                  freeze;
    logic                  bubble;
    logic                  flush;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [CNT_WIDTH-1:0]  stall_count;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dst, id_mem_read,
        output branch_taken, mem_ready,
        input  freeze, bubble, flush, stage_valid, stall_count
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dst, id_mem_read,
        input  branch_taken, mem_ready,
        output freeze, bubble, flush, stage_valid, stall_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sb_entry_cmp.sv
// Compares one scoreboard entry against the two ID source indices.
// LOAD_ONLY restricts matches to load producers (forwarding mode, entry 0).
module sb_entry_cmp
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter bit LOAD_ONLY = 1'b0
) (
    input  sb_entry_t            entry,
    input  logic [REG_DEPTH-1:0] src1,
    input  logic [REG_DEPTH-1:0] src2,
    input  logic                 two_src,
    output logic                 match1,
    output logic                 match2
);
    logic producer;

    assign producer = entry.valid & entry.wb_en & (!LOAD_ONLY || entry.mem_read);
    assign match1   = producer & (entry.dst == src1);
    assign match2   = producer & two_src & (entry.dst == src2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard-based stall/flush controller for the IF/ID/EXE registers.
// Entry 0 is EXE; the last entry is WB and still counts as a hazard.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter bit FORWARD_EN = 1'b0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    pipeline_hazard_ctrl_if.slave   hz
);
    sb_entry_t [NUM_STAGES-1:0] sb;
    logic      [NUM_STAGES-1:0] m1;
    logic      [NUM_STAGES-1:0] m2;
    logic      [NUM_STAGES-1:0] vld;
    logic      [CNT_WIDTH-1:0]  cnt;
    sb_entry_t                  new_e;
    logic                       hazard;
    logic                       flush_c;
    logic                       bubble_c;
    logic                       freeze_c;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_cmp
        sb_entry_cmp #(
            .LOAD_ONLY (FORWARD_EN && (g == 0))
        ) u_cmp (
            .entry   (sb[g]),
            .src1    (hz.id_src1),
            .src2    (hz.id_src2),
            .two_src (hz.id_two_src),
            .match1  (m1[g]),
            .match2  (m2[g])
        );
        assign vld[g] = sb[g].valid;
    end

    // With forwarding only a load sitting in EXE cannot be bypassed.
    assign hazard   = hz.id_valid & (FORWARD_EN ? (m1[0] | m2[0]) : |(m1 | m2));
    assign flush_c  = hz.branch_taken & hz.mem_ready;
    assign bubble_c = hz.mem_ready & hazard & ~flush_c;
    assign freeze_c = ~hz.mem_ready | (hazard & ~flush_c);

    assign hz.flush       = ~rst & flush_c;
    assign hz.bubble      = ~rst & bubble_c;
    assign hz.freeze      = ~rst & freeze_c;
    assign hz.stage_valid = rst ? '0 : vld;
    assign hz.stall_count = rst ? '0 : cnt;

    always_comb begin
        new_e = SB_NOP;
        if (hz.id_valid && !flush_c && !hazard) begin
            new_e.valid    = 1'b1;
            new_e.wb_en    = hz.id_wb_en;
            new_e.dst      = hz.id_dst;
            new_e.mem_read = hz.id_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb  <= {NUM_STAGES{SB_NOP}};
            cnt <= '0;
        end else begin
            // Memory back-pressure freezes the whole pipe, scoreboard included.
            if (hz.mem_ready) begin
                for (int k = NUM_STAGES - 1; k > 0; k--) sb[k] <= sb[k-1];
                sb[0] <= new_e;
            end
            if (bubble_c && cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule
